// File: rtl/clock_ratio_meter_if.sv
// Measured-clock control and measurement results shared by the meter and its user.
interface clock_ratio_meter_if #(
  parameter int unsigned counter_width = 16
);
  logic                     measured_clock;
  logic                     enable;
  logic [counter_width-1:0] period;
  logic [counter_width-1:0] high_time;
  logic                     period_valid;
  logic                     locked;
  logic                     clock_lost;

  // Driver side: supplies the clock under test and the enable, reads results.
  modport master (
    output measured_clock,
    output enable,
    input  period,
    input  high_time,
    input  period_valid,
    input  locked,
    input  clock_lost
  );

  // Meter side.
  modport slave (
    input  measured_clock,
    input  enable,
    output period,
    output high_time,
    output period_valid,
    output locked,
    output clock_lost
  );
endinterface

// File: rtl/clock_ratio_meter.sv
// Measures period and high time of a slow asynchronous clock in input_clock cycles,
// flags lock on a stable ratio and loss of clock. All outputs are registered.
module clock_ratio_meter #(
  parameter int unsigned counter_width = 16,
  parameter int unsigned sync_stages   = 2,
  parameter int unsigned lock_count    = 4,
  parameter int unsigned loss_limit    = 65535
) (
  input logic                input_clock,
  input logic                reset,
  clock_ratio_meter_if.slave bus
);

  localparam logic [counter_width-1:0] LossLimit = counter_width'(loss_limit);
  localparam logic [counter_width-1:0] CntOne    = counter_width'(1);
  localparam logic [3:0]               LockMax   = 4'(lock_count);

  typedef enum logic [1:0] {StIdle, StArm, StMeasure, StLost} state_e;

  state_e                   state_q, state_d;
  logic [sync_stages-1:0]   sync_q;
  logic                     prev_q;
  logic [counter_width-1:0] cnt_q, cnt_d, cnt_inc;
  logic [counter_width-1:0] period_q, period_d;
  logic [counter_width-1:0] high_q, high_d;
  logic                     valid_q, valid_d;
  logic [3:0]               lock_cnt_q, lock_cnt_d;
  logic                     locked_q, locked_d;
  logic                     lost_q, lost_d;
  logic                     s, rise, fall;

  assign s       = sync_q[sync_stages-1];
  assign rise    = s & ~prev_q;
  assign fall    = ~s & prev_q;
  // Saturate so a dead clock never wraps back into a plausible period.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CntOne;

  // Synchroniser chain and edge-detect register for the clock under test.
  always_ff @(posedge input_clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[sync_stages-2:0], bus.measured_clock};
      prev_q <= s;
    end
  end

  // FSM state register.
  always_ff @(posedge input_clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; dropping enable returns to idle from anywhere.
  always_comb begin
    state_d = state_q;
    if (!bus.enable) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:    state_d = StArm;
        StArm:     if (rise) state_d = StMeasure;
        StMeasure: if (!rise && (cnt_q == LossLimit)) state_d = StLost;
        StLost:    if (rise) state_d = StMeasure;
        default:   state_d = StIdle;
      endcase
    end
  end

  // FSM outputs: next values of the counter, measurements and status flags.
  always_comb begin
    cnt_d      = cnt_q;
    period_d   = period_q;
    high_d     = high_q;
    valid_d    = 1'b0;
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    lost_d     = lost_q;
    if (!bus.enable) begin
      cnt_d      = '0;
      lock_cnt_d = '0;
      locked_d   = 1'b0;
      lost_d     = 1'b0;
    end else begin
      case (state_q)
        StIdle: cnt_d = '0;
        StArm: begin
          // First edge only aligns the counter; no period is known yet.
          cnt_d      = rise ? CntOne : cnt_inc;
          lock_cnt_d = '0;
          locked_d   = 1'b0;
          lost_d     = 1'b0;
        end
        StMeasure: begin
          cnt_d = rise ? CntOne : cnt_inc;
          if (fall) high_d = cnt_q;
          if (rise) begin
            period_d = cnt_q;
            valid_d  = 1'b1;
            // Lock count of 0 marks the first period after arming or a loss.
            if (lock_cnt_q == 4'd0 || cnt_q != period_q) begin
              lock_cnt_d = 4'd1;
            end else if (lock_cnt_q != LockMax) begin
              lock_cnt_d = lock_cnt_q + 4'd1;
            end
            locked_d = (lock_cnt_d == LockMax);
          end else if (cnt_q == LossLimit) begin
            lost_d     = 1'b1;
            locked_d   = 1'b0;
            lock_cnt_d = '0;
          end
        end
        StLost: begin
          // The recovering edge restarts timing but measures nothing.
          cnt_d = rise ? CntOne : cnt_inc;
          if (rise) lost_d = 1'b0;
        end
        default: cnt_d = '0;
      endcase
    end
  end

  // Datapath and output registers.
  always_ff @(posedge input_clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      period_q   <= '0;
      high_q     <= '0;
      valid_q    <= 1'b0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      period_q   <= period_d;
      high_q     <= high_d;
      valid_q    <= valid_d;
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
      lost_q     <= lost_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.high_time    = high_q;
  assign bus.period_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.clock_lost   = lost_q;

endmodule

// File: tb/tb_clock_ratio_meter.sv
// Directed bench: table of measured-clock periods with the pulse each rising edge
// should produce, plus hand sequences for loss, disable, reset and edge latency.
module tb_clock_ratio_meter;

  typedef struct {
    int unsigned p;
    int unsigned h;
    bit          v;
    logic [15:0] ep;
    logic [15:0] eh;
    logic        el;
  } row_t;

  typedef struct {
    logic [15:0] period;
    logic [15:0] high;
    logic        locked;
  } pulse_t;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   cyc;
  int   last_valid_cyc;
  int   lost_cyc;
  logic lost_prev;
  row_t   tbl[$];
  pulse_t obs_q[$];
  pulse_t exp_q[$];

  clock_ratio_meter_if #(.counter_width(16)) bus ();

  clock_ratio_meter #(
    .counter_width(16),
    .sync_stages  (2),
    .lock_count   (4),
    .loss_limit   (100)
  ) dut (
    .input_clock(clk),
    .reset      (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every period_valid pulse and the cycles of key events.
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    lost_prev <= bus.clock_lost;
    if (bus.period_valid) begin
      obs_q.push_back(pulse_t'{bus.period, bus.high_time, bus.locked});
      last_valid_cyc <= cyc;
    end
    if (bus.clock_lost && !lost_prev) lost_cyc <= cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int unsigned p, input int unsigned h, input bit v,
                              input logic [15:0] ep, input logic [15:0] eh, input logic el);
    tbl.push_back(row_t'{p, h, v, ep, eh, el});
  endfunction

  task automatic expect_pulse(input logic [15:0] ep, input logic [15:0] eh, input logic el);
    exp_q.push_back(pulse_t'{ep, eh, el});
  endtask

  // One measured-clock period starting with a rising edge.
  task automatic drive_row(input row_t r);
    if (r.v) expect_pulse(r.ep, r.eh, r.el);
    bus.measured_clock = 1'b1;
    repeat (r.h) tick();
    bus.measured_clock = 1'b0;
    repeat (r.p - r.h) tick();
  endtask

  task automatic compare_pulses(input string name);
    repeat (4) tick();
    check({name, " pulse count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++;
      if (obs_q[i].period !== exp_q[i].period || obs_q[i].high !== exp_q[i].high ||
          obs_q[i].locked !== exp_q[i].locked) begin
        fails++;
        $display("FAIL %s pulse %0d: got period=%0d high=%0d locked=%0d, expected %0d/%0d/%0d",
                 name, i, obs_q[i].period, obs_q[i].high, obs_q[i].locked,
                 exp_q[i].period, exp_q[i].high, exp_q[i].locked);
      end
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    last_valid_cyc = 0;
    lost_cyc = 0;
    lost_prev = 1'b0;
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.measured_clock = 1'b0;

    // Segment 1: 8 (50%) -> 10 (50%) -> 2 (50%) -> 6 (high 2), ends locked.
    add(8, 4, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(8, 4, 1, 8, 4, 0);
    add(8, 4, 1, 8, 4, 1);
    add(8, 4, 1, 8, 4, 1);
    add(10, 5, 1, 8, 4, 1);
    for (int i = 0; i < 3; i++) add(10, 5, 1, 10, 5, 0);
    add(10, 5, 1, 10, 5, 1);
    add(2, 1, 1, 10, 5, 1);
    for (int i = 0; i < 3; i++) add(2, 1, 1, 2, 1, 0);
    add(2, 1, 1, 2, 1, 1);
    add(2, 1, 1, 2, 1, 1);
    add(6, 2, 1, 2, 1, 1);
    for (int i = 0; i < 3; i++) add(6, 2, 1, 6, 2, 0);
    add(6, 2, 1, 6, 2, 1);
    // Segment 2 (rows 22..26) follows a hand-driven recovery edge.
    for (int i = 0; i < 3; i++) add(8, 4, 1, 8, 4, 0);
    add(8, 4, 1, 8, 4, 1);
    add(8, 4, 1, 8, 4, 1);
    // Segment 3 (rows 27..29) after re-enable.
    add(4, 1, 0, 0, 0, 0);
    add(4, 1, 1, 4, 1, 0);
    add(4, 1, 1, 4, 1, 0);
    // Segment 4 (row 30) after reset.
    add(6, 3, 1, 6, 3, 0);

    repeat (3) tick();
    check("reset period", bus.period, 0);
    check("reset high_time", bus.high_time, 0);
    check("reset period_valid", bus.period_valid, 0);
    check("reset locked", bus.locked, 0);
    check("reset clock_lost", bus.clock_lost, 0);
    rst_n = 1'b1;
    tick();
    bus.enable = 1'b1;
    tick();

    for (int i = 0; i < 22; i++) drive_row(tbl[i]);
    compare_pulses("seg1");
    check("locked before loss", bus.locked, 1);

    // Loss of clock: measured_clock held low.
    for (int i = 0; i < 200 && !bus.clock_lost; i++) tick();
    check("clock_lost asserted", bus.clock_lost, 1);
    check("locked when lost", bus.locked, 0);
    tick();
    check("loss delay", lost_cyc - last_valid_cyc, 100);

    // Recovery edge clears clock_lost without a pulse.
    bus.measured_clock = 1'b1;
    tick();
    tick();
    check("lost before edge seen", bus.clock_lost, 1);
    tick();
    check("lost cleared by edge", bus.clock_lost, 0);
    tick();
    bus.measured_clock = 1'b0;
    repeat (4) tick();
    for (int i = 22; i < 27; i++) drive_row(tbl[i]);
    compare_pulses("seg2");

    // Disable while locked.
    check("locked before disable", bus.locked, 1);
    bus.enable = 1'b0;
    tick();
    check("disable drops locked", bus.locked, 0);
    check("disable holds period", bus.period, 8);
    check("disable holds high_time", bus.high_time, 4);
    repeat (3) tick();
    check("idle stays unlocked", bus.locked, 0);
    check("idle no pulse", bus.period_valid, 0);
    bus.enable = 1'b1;
    for (int i = 27; i < 30; i++) drive_row(tbl[i]);
    compare_pulses("seg3");

    // Asynchronous reset in the middle of a measurement.
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset period", bus.period, 0);
    check("async reset high_time", bus.high_time, 0);
    check("async reset valid", bus.period_valid, 0);
    check("async reset locked", bus.locked, 0);
    check("async reset lost", bus.clock_lost, 0);
    #3;
    rst_n = 1'b1;
    tick();

    // Arming edge, then pin-edge-to-pulse latency of sync_stages+1 cycles.
    bus.measured_clock = 1'b1;
    repeat (3) tick();
    bus.measured_clock = 1'b0;
    repeat (3) tick();
    bus.measured_clock = 1'b1;
    expect_pulse(6, 3, 0);
    tick();
    check("latency cycle 1", bus.period_valid, 0);
    tick();
    check("latency cycle 2", bus.period_valid, 0);
    tick();
    check("latency cycle 3", bus.period_valid, 1);
    check("first period after reset", bus.period, 6);
    bus.measured_clock = 1'b0;
    repeat (3) tick();
    drive_row(tbl[30]);
    compare_pulses("seg4");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
